// File: rtl/txq_pkg.sv
// Shared encodings for the TX slot scheduler: mux select codes and FSM states.
package txq_pkg;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_REQ  = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_NET  = 2'b11;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } txq_state_t;

endpackage

// File: rtl/txq_sched_pause_hyst.sv
// Hysteresis backpressure register: asserts below ON free entries, releases at OFF or more.
// One-cycle latency from i_space; holds its value inside the ON..OFF band.
module pause_hyst #(
    parameter int ON  = 26,
    parameter int OFF = 30,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_space,
    output logic         o_pause
);

    logic r_pause;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pause <= 1'b0;
        end else if (i_space < W'(ON)) begin
            r_pause <= 1'b1;
        end else if (i_space >= W'(OFF)) begin
            r_pause <= 1'b0;
        end
    end

    assign o_pause = r_pause;

endmodule

// File: rtl/txq_sched.sv
// Per-slot TX scheduler sharing the PHY slot between MEM, REQ and NET FWFT queues.
// Zero-latency select/pop; bounded MEM bursts, NET aging, frame-atomic NET grants.
module txq_sched
    import txq_pkg::*;
#(
    parameter int MEM_BURST    = 4,
    parameter int NET_MAX_WAIT = 16,
    parameter int PAUSE_ON     = 26,
    parameter int PAUSE_OFF    = 30,
    parameter int SPACE_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               slot_en,
    input  logic               memq_empty,
    input  logic               reqq_empty,
    input  logic               netq_empty,
    input  logic               netq_last,
    input  logic [SPACE_W-1:0] netq_space,
    output logic               memq_read,
    output logic               reqq_read,
    output logic               netq_read,
    output logic [1:0]         sel,
    output logic               memq_reset,
    output logic               reqq_reset,
    output logic               netq_reset,
    output logic               tx_pause,
    output logic               net_underrun
);

    localparam int RUN_W  = $clog2(MEM_BURST + 1);
    localparam int WAIT_W = $clog2(NET_MAX_WAIT + 1);

    txq_state_t        r_state;
    logic [RUN_W-1:0]  r_mem_run;
    logic [WAIT_W-1:0] r_net_wait;
    logic              r_qreset;

    logic       w_slot;
    logic [1:0] w_sel;
    logic       w_underrun;

    // Queues are still held in reset until the first clock after release, so no pops then.
    assign w_slot = slot_en & ~r_qreset;

    always_comb begin
        w_sel      = SEL_IDLE;
        w_underrun = 1'b0;
        if (w_slot) begin
            if (r_state == LOCK) begin
                if (!netq_empty) begin
                    w_sel = SEL_NET;
                end else begin
                    w_underrun = 1'b1;
                end
            end else if (r_net_wait == WAIT_W'(NET_MAX_WAIT) && !netq_empty) begin
                w_sel = SEL_NET;
            end else if (!memq_empty && !(r_mem_run == RUN_W'(MEM_BURST) && !reqq_empty)) begin
                w_sel = SEL_MEM;
            end else if (!reqq_empty) begin
                w_sel = SEL_REQ;
            end else if (!memq_empty) begin
                w_sel = SEL_MEM;
            end else if (!netq_empty) begin
                w_sel = SEL_NET;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB;
            r_mem_run  <= '0;
            r_net_wait <= '0;
            r_qreset   <= 1'b1;
        end else begin
            r_qreset <= 1'b0;
            if (w_slot) begin
                if (w_sel != SEL_MEM) begin
                    r_mem_run <= '0;
                end else if (r_mem_run != RUN_W'(MEM_BURST)) begin
                    r_mem_run <= r_mem_run + 1'b1;
                end

                if (w_sel == SEL_NET || netq_empty) begin
                    r_net_wait <= '0;
                end else if (r_net_wait != WAIT_W'(NET_MAX_WAIT)) begin
                    r_net_wait <= r_net_wait + 1'b1;
                end

                if (w_sel == SEL_NET) begin
                    r_state <= netq_last ? ARB : LOCK;
                end
            end
        end
    end

    pause_hyst #(
        .ON  (PAUSE_ON),
        .OFF (PAUSE_OFF),
        .W   (SPACE_W)
    ) u_pause (
        .clk     (clk),
        .reset   (reset),
        .i_space (netq_space),
        .o_pause (tx_pause)
    );

    assign sel          = w_sel;
    assign memq_read    = (w_sel == SEL_MEM);
    assign reqq_read    = (w_sel == SEL_REQ);
    assign netq_read    = (w_sel == SEL_NET);
    assign net_underrun = w_underrun;
    assign memq_reset   = r_qreset;
    assign reqq_reset   = r_qreset;
    assign netq_reset   = r_qreset;

endmodule

// File: tb/tb_txq_sched.sv
// Bench for txq_sched: vector table, directed corner sequences and random traffic vs a rule model.
module tb_txq_sched;

    logic       clk;
    logic       reset;
    logic       slot_en;
    logic       memq_empty;
    logic       reqq_empty;
    logic       netq_empty;
    logic       netq_last;
    logic [5:0] netq_space;
    logic       memq_read;
    logic       reqq_read;
    logic       netq_read;
    logic [1:0] sel;
    logic       memq_reset;
    logic       reqq_reset;
    logic       netq_reset;
    logic       tx_pause;
    logic       net_underrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, kept as plain integers.
    bit m_lock;
    int m_run;
    int m_wait;
    bit m_pause;
    bit m_qrst;
    logic [1:0] obs_sel;
    logic       obs_und;
    logic       obs_mrd;

    txq_sched dut (
        .clk          (clk),
        .reset        (reset),
        .slot_en      (slot_en),
        .memq_empty   (memq_empty),
        .reqq_empty   (reqq_empty),
        .netq_empty   (netq_empty),
        .netq_last    (netq_last),
        .netq_space   (netq_space),
        .memq_read    (memq_read),
        .reqq_read    (reqq_read),
        .netq_read    (netq_read),
        .sel          (sel),
        .memq_reset   (memq_reset),
        .reqq_reset   (reqq_reset),
        .netq_reset   (netq_reset),
        .tx_pause     (tx_pause),
        .net_underrun (net_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_lock  = 0;
        m_run   = 0;
        m_wait  = 0;
        m_pause = 0;
        m_qrst  = 1;
    endfunction

    function automatic logic [1:0] exp_grant();
        if (!slot_en || m_qrst || reset) return 2'b00;
        if (m_lock) return netq_empty ? 2'b00 : 2'b11;
        if (m_wait >= 16 && !netq_empty) return 2'b11;
        if (!memq_empty && !(m_run >= 4 && !reqq_empty)) return 2'b10;
        if (!reqq_empty) return 2'b01;
        if (!memq_empty) return 2'b10;
        if (!netq_empty) return 2'b11;
        return 2'b00;
    endfunction

    function automatic void model_update(logic [1:0] g);
        if (slot_en && !m_qrst) begin
            m_run  = (g == 2'b10) ? ((m_run < 4) ? m_run + 1 : 4) : 0;
            m_wait = (g == 2'b11 || netq_empty) ? 0 : ((m_wait < 16) ? m_wait + 1 : 16);
            if (g == 2'b11) m_lock = !netq_last;
        end
        if (netq_space < 26) m_pause = 1;
        else if (netq_space >= 30) m_pause = 0;
        m_qrst = 0;
    endfunction

    // One slot: check comb outputs mid-cycle, then clock and advance the model.
    task automatic do_slot();
        logic [1:0] g;
        bit und;
        @(negedge clk);
        g   = exp_grant();
        und = slot_en && !m_qrst && !reset && m_lock && netq_empty;
        obs_sel = sel;
        obs_und = net_underrun;
        obs_mrd = memq_read;
        chk("sel", sel, g);
        chk("memq_read", memq_read, g == 2'b10);
        chk("reqq_read", reqq_read, g == 2'b01);
        chk("netq_read", netq_read, g == 2'b11);
        chk("net_underrun", net_underrun, und);
        chk("tx_pause", tx_pause, m_pause);
        chk("q_resets", {memq_reset, reqq_reset, netq_reset}, m_qrst ? 7 : 0);
        @(posedge clk);
        if (!reset) model_update(g);
        #1;
    endtask

    task automatic set_q(input logic sen, input logic me, input logic re,
                         input logic ne, input logic nl);
        slot_en    = sen;
        memq_empty = me;
        reqq_empty = re;
        netq_empty = ne;
        netq_last  = nl;
    endtask

    task automatic clear_counters();
        set_q(1, 1, 1, 1, 1);
        do_slot();
    endtask

    typedef struct {
        logic       sen, me, re, ne, nl;
        logic [1:0] sel;
        logic       und;
    } vec_t;

    vec_t tbl[13];
    int   burst_exp[10];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0};
        burst_exp = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

        reset      = 1'b1;
        netq_space = 6'd40;
        set_q(1, 0, 0, 0, 1);
        model_reset();
        do_slot();
        do_slot();
        reset = 1'b0;
        do_slot();
        chk("reset_released", memq_reset, 0);

        // Vector table from a freshly reset scheduler.
        foreach (tbl[i]) begin
            set_q(tbl[i].sen, tbl[i].me, tbl[i].re, tbl[i].ne, tbl[i].nl);
            do_slot();
            chk("tbl_sel", obs_sel, tbl[i].sel);
            chk("tbl_underrun", obs_und, tbl[i].und);
        end

        // MEM burst limit with REQ waiting.
        clear_counters();
        set_q(1, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            do_slot();
            chk("burst_sel", obs_sel, burst_exp[i]);
        end

        // NET aging, twice in a row to show the wait counter restarts.
        clear_counters();
        for (int r = 0; r < 2; r++) begin
            set_q(1, 0, 1, 0, 1);
            for (int i = 0; i < 17; i++) begin
                do_slot();
                chk("aging_sel", obs_sel, (i == 16) ? 3 : 2);
            end
        end

        // Frame atomicity: 5-word frame starting via aging while MEM is busy.
        clear_counters();
        set_q(1, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) do_slot();
        for (int i = 0; i < 5; i++) begin
            netq_last = (i == 4);
            do_slot();
            chk("frame_sel", obs_sel, 3);
        end
        do_slot();
        chk("frame_after", obs_sel, 2);

        // Underrun inside a locked frame.
        clear_counters();
        set_q(1, 1, 1, 0, 0);
        do_slot();
        chk("ur_start", obs_sel, 3);
        set_q(1, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            do_slot();
            chk("ur_sel", obs_sel, 0);
            chk("ur_pulse", obs_und, 1);
            chk("ur_memrd", obs_mrd, 0);
        end
        set_q(1, 0, 0, 0, 0);
        do_slot();
        chk("ur_resume", obs_sel, 3);
        netq_last = 1'b1;
        do_slot();
        chk("ur_last", obs_sel, 3);
        set_q(1, 0, 1, 1, 1);
        do_slot();
        chk("ur_after", obs_sel, 2);

        // Pause hysteresis.
        netq_space = 6'd40;
        do_slot();
        chk("pause_40", tx_pause, 0);
        netq_space = 6'd25;
        do_slot();
        chk("pause_25", tx_pause, 1);
        netq_space = 6'd28;
        do_slot();
        chk("pause_28", tx_pause, 1);
        netq_space = 6'd30;
        do_slot();
        chk("pause_30", tx_pause, 0);

        // Reset asserted mid-frame drops the lock.
        clear_counters();
        netq_space = 6'd20;
        set_q(1, 1, 1, 0, 0);
        do_slot();
        do_slot();
        reset = 1'b1;
        model_reset();
        set_q(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do_slot();
            chk("rst_sel", obs_sel, 0);
            chk("rst_qreset", netq_reset, 1);
            chk("rst_pause", tx_pause, 0);
        end
        reset = 1'b0;
        netq_space = 6'd40;
        do_slot();
        do_slot();
        chk("rst_arb_sel", obs_sel, 2);
        chk("rst_released", memq_reset, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            slot_en    = ($urandom_range(0, 9) != 0);
            memq_empty = ($urandom_range(0, 2) == 0);
            reqq_empty = ($urandom_range(0, 1) == 0);
            netq_empty = ($urandom_range(0, 3) == 0);
            netq_last  = ($urandom_range(0, 3) == 0);
            netq_space = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                     : 6'($urandom_range(22, 34));
            do_slot();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/txq_sched.md
Name: txq_sched

Overview:
- Per-slot TX scheduler that shares the single 64-bit PHY transmit slot between three FWFT queues: memory-response (MEM), request (REQ) and network-frame (NET).
- Sits between the queue FIFOs and the TX block-mux. It drives `sel` and the read strobes, and produces `tx_pause` back to the MAC (tx_axis_tready gating).
- Adds three things over plain strict priority: bounded MEM bursts, NET anti-starvation aging, and frame-atomic NET grants. `tx_pause` uses hysteresis.

Parameters:
- MEM_BURST, 4: max consecutive MEM grants while REQ is non-empty.
- NET_MAX_WAIT, 16: slots NET may wait while non-empty before a forced grant.
- PAUSE_ON, 26: assert pause when netq_space < PAUSE_ON.
- PAUSE_OFF, 30: deassert pause when netq_space >= PAUSE_OFF. Must be >= PAUSE_ON.
- SPACE_W, 6: width of netq_space.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- slot_en  in  1  TX slot available this cycle; grants only occur when high
- memq_empty  in  1  MEM queue empty
- reqq_empty  in  1  REQ queue empty
- netq_empty  in  1  NET queue empty
- netq_last  in  1  NET head word is last word of its frame
- netq_space  in  SPACE_W  free entries in NET queue
- memq_read  out  1  pop MEM head
- reqq_read  out  1  pop REQ head
- netq_read  out  1  pop NET head
- sel  out  2  00 idle, 01 REQ, 10 MEM, 11 NET
- memq_reset  out  1  queue reset
- reqq_reset  out  1  queue reset
- netq_reset  out  1  queue reset
- tx_pause  out  1  MAC backpressure
- net_underrun  out  1  one-cycle pulse: NET frame locked but netq empty in a slot

Behaviour:
- Timing
  - `sel` and the read strobes are combinational from registered state plus the current empty flags and `slot_en` (zero-latency FWFT pop).
  - At most one read strobe is high per cycle.
  - A strobe is never high for an empty queue or when `slot_en`=0.
- Reset values
  - During reset: state=ARB, mem_run=0, net_wait=0, tx_pause=0, net_underrun=0, all *_reset=1.
  - First clock after reset release: all *_reset go 0 and stay 0.
  - Reset asserted mid-frame drops the NET lock immediately.
- State ARB, with `slot_en`=1, first matching rule wins:
  1. NET forced: net_wait==NET_MAX_WAIT and !netq_empty -> grant NET.
  2. MEM: !memq_empty and not (mem_run==MEM_BURST and !reqq_empty) -> grant MEM.
  3. REQ: !reqq_empty -> grant REQ.
  4. MEM fallback: !memq_empty -> grant MEM. Only reachable if REQ is empty.
  5. NET: !netq_empty -> grant NET.
  6. Otherwise sel=00, no read.
- Transitions from ARB
  - NET grant with netq_last=0 -> LOCK.
  - NET grant with netq_last=1 -> stay ARB.
- State LOCK, with `slot_en`=1
  - !netq_empty: grant NET. If netq_last=1 -> ARB.
  - netq_empty: sel=00, net_underrun=1 for that cycle, stay LOCK.
  - MEM and REQ are never granted in LOCK.
- `slot_en`=0: sel=00, no reads, no state or counter change.
- mem_run (saturating at MEM_BURST)
  - MEM grant -> +1.
  - Any non-MEM grant, or an idle slot -> cleared to 0.
- net_wait (saturating at NET_MAX_WAIT)
  - Slot with netq non-empty and no NET grant -> +1.
  - Any NET grant, or netq_empty -> cleared to 0.
- tx_pause (registered)
  - Set when netq_space < PAUSE_ON.
  - Cleared when netq_space >= PAUSE_OFF.
  - Otherwise holds.
  - Updates every cycle regardless of `slot_en`.

Decomposition:
- Shared package `txq_pkg`:
  - sel encodings SEL_IDLE/SEL_REQ/SEL_MEM/SEL_NET.
  - FSM state enum ARB/LOCK.
- Sub-module `pause_hyst`: the hysteresis comparator register, reusable for other queue backpressure.
- All other logic stays inline.

Test Plan:
- Reset: assert reset for 3 cycles mid-LOCK -> all *_reset=1, tx_pause=0, sel=00. One cycle after release, *_reset=0 and state=ARB.
- MEM burst limit: MEM and REQ both non-empty, slot_en=1 -> sel sequence 10,10,10,10,01,10,10,10,10,01.
- NET aging: MEM continuously non-empty, REQ empty, NET non-empty -> after 16 MEM slots, slot 17 gives sel=11 with netq_read=1; net_wait returns to 0.
- Frame atomicity: NET frame of 5 words starts while MEM is non-empty -> 5 consecutive sel=11, then sel=10.
- Underrun: in LOCK, netq_empty=1 for 2 slots -> sel=00 both slots, net_underrun pulses each cycle, no memq_read; frame resumes when data returns.
- Pause hysteresis: netq_space 40->25 -> tx_pause=1 the next cycle. Space 28 -> stays 1. Space 30 -> tx_pause=0 the next cycle.
